// File: rtl/multicycle_control_unit_if.sv
//------------------------------------------------------------------------------
// multicycle_control_unit_if
// Control/status bundle between the multicycle sequencer and its datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_unit_if #(
   parameter int Count_Width = 32
);
   logic [5:0]             OpCode;
   logic [5:0]             Funct;
   logic                   Zero;
   logic                   PCEn;
   logic                   IorD;
   logic                   MemWrite;
   logic                   IRWrite;
   logic                   RegWrite;
   logic                   RegDst;
   logic                   MemToReg;
   logic                   ALUSrcA;
   logic [1:0]             ALUSrcB;
   logic [1:0]             PCSrc;
   logic [2:0]             ALUControl;
   logic [3:0]             State;
   logic [Count_Width-1:0] Retired_Count;
   logic                   Illegal;

   // master = control unit, slave = datapath side
   modport master (
      input  OpCode, Funct, Zero,
      output PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
             ALUSrcA, ALUSrcB, PCSrc, ALUControl, State, Retired_Count, Illegal
   );

   modport slave (
      output OpCode, Funct, Zero,
      input  PCEn, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
             ALUSrcA, ALUSrcB, PCSrc, ALUControl, State, Retired_Count, Illegal
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
//------------------------------------------------------------------------------
// multicycle_control_unit
// Moore sequencer for the multicycle MIPS datapath with retire counter and
// sticky illegal-instruction flag. Optional bne support: MULTICYCLE_BNE_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control_unit #(
   parameter int Count_Width = 32
) (
   input  logic                      CLK,
   input  logic                      RST,
   multicycle_control_unit_if.master bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
`ifdef MULTICYCLE_BNE_EN
      , BNEEX = 4'd12
`endif
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       branch_ne;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [2:0] alu_control;
   } ctl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
   localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t                 state;
   state_t                 next_state;
   ctl_t                   ctl;
   logic                   retire;
   logic                   mark_illegal;
   logic [Count_Width-1:0] retired;
   logic                   illegal;

   function automatic logic funct_ok(input logic [5:0] f);
      return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
             (f == FN_OR)  || (f == FN_SLT);
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   // Control word for a state; Funct only matters when entering RTYPEEX.
   function automatic ctl_t ctl_for(input state_t s, input logic [5:0] f);
      ctl_t c;
      c             = '0;
      c.alu_control = ALU_ADD;
      case (s)
         FETCH: begin
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         DECODE:  c.alu_src_b = 2'b11;
         MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         MEMRD:   c.iord = 1'b1;
         MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
         end
         RTYPEEX: begin
            c.alu_src_a   = 1'b1;
            c.alu_control = funct_alu(f);
         end
         RTYPEWB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         BEQEX: begin
            c.alu_src_a   = 1'b1;
            c.alu_control = ALU_SUB;
            c.pc_src      = 2'b01;
            c.branch      = 1'b1;
         end
`ifdef MULTICYCLE_BNE_EN
         BNEEX: begin
            c.alu_src_a   = 1'b1;
            c.alu_control = ALU_SUB;
            c.pc_src      = 2'b01;
            c.branch_ne   = 1'b1;
         end
`endif
         ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         ADDIWB:  c.reg_write = 1'b1;
         JEX: begin
            c.pc_write = 1'b1;
            c.pc_src   = 2'b10;
         end
         default: c.alu_control = ALU_ADD;
      endcase
      return c;
   endfunction

   always_comb begin
      next_state   = FETCH;
      mark_illegal = 1'b0;
      retire       = 1'b0;
      case (state)
         FETCH:  next_state = DECODE;
         DECODE: begin
            case (bus.OpCode)
               OP_LW, OP_SW: next_state = MEMADR;
               OP_RTYPE: begin
                  if (funct_ok(bus.Funct)) next_state = RTYPEEX;
                  else                     mark_illegal = 1'b1;
               end
               OP_BEQ:  next_state = BEQEX;
               OP_ADDI: next_state = ADDIEX;
               OP_J:    next_state = JEX;
`ifdef MULTICYCLE_BNE_EN
               OP_BNE:  next_state = BNEEX;
`endif
               default: mark_illegal = 1'b1;
            endcase
         end
         MEMADR:  next_state = (bus.OpCode == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   next_state = MEMWB;
         RTYPEEX: next_state = RTYPEWB;
         ADDIEX:  next_state = ADDIWB;
         MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX
`ifdef MULTICYCLE_BNE_EN
         , BNEEX
`endif
         :        retire = 1'b1;
         default: next_state = FETCH;
      endcase
   end

   // Control word is registered alongside the state it belongs to.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= FETCH;
         ctl     <= ctl_for(FETCH, 6'b000000);
         retired <= '0;
         illegal <= 1'b0;
      end else begin
         state <= next_state;
         ctl   <= ctl_for(next_state, bus.Funct);
         if (retire)       retired <= retired + Count_Width'(1);
         if (mark_illegal) illegal <= 1'b1;
      end
   end

   assign bus.PCEn          = ~RST & (ctl.pc_write | (ctl.branch & bus.Zero) |
                                      (ctl.branch_ne & ~bus.Zero));
   assign bus.MemWrite      = ~RST & ctl.mem_write;
   assign bus.IRWrite       = ~RST & ctl.ir_write;
   assign bus.RegWrite      = ~RST & ctl.reg_write;
   assign bus.IorD          = ctl.iord;
   assign bus.RegDst        = ctl.reg_dst;
   assign bus.MemToReg      = ctl.mem_to_reg;
   assign bus.ALUSrcA       = ctl.alu_src_a;
   assign bus.ALUSrcB       = ctl.alu_src_b;
   assign bus.PCSrc         = ctl.pc_src;
   assign bus.ALUControl    = ctl.alu_control;
   assign bus.State         = state;
   assign bus.Retired_Count = retired;
   assign bus.Illegal       = illegal;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
//------------------------------------------------------------------------------
// tb_multicycle_control_unit
// Self-checking bench: vector table, random instruction stream, corner cases.
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control_unit;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   multicycle_control_unit_if #(.Count_Width(32)) bus ();
   multicycle_control_unit_if #(.Count_Width(4))  bus_w ();

   multicycle_control_unit #(.Count_Width(32)) dut   (.CLK(CLK), .RST(RST), .bus(bus));
   multicycle_control_unit #(.Count_Width(4))  dut_w (.CLK(CLK), .RST(RST), .bus(bus_w));

   assign bus_w.OpCode = bus.OpCode;
   assign bus_w.Funct  = bus.Funct;
   assign bus_w.Zero   = bus.Zero;

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      int         zmode;   // 0/1 fixed Zero, 2 random
      int         n;
      int         seq[5];
   } vec_t;

   vec_t        tbl[12];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_count;
   logic        m_ill;
   int          s5[5];
   int          n;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [14:0] act_ctl();
      return {bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.RegDst,
              bus.MemToReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUControl};
   endfunction

   // Expected outputs straight from the per-state output list.
   function automatic logic [14:0] exp_ctl(input int s, input logic [5:0] f, input logic z);
      logic       pcen, iord, mw, irw, rw, rd, m2r, sa;
      logic [1:0] sb, ps;
      logic [2:0] alu;
      {pcen, iord, mw, irw, rw, rd, m2r, sa} = 8'b0;
      sb = 2'b00; ps = 2'b00; alu = 3'b010;
      case (s)
         0:  begin pcen = 1; irw = 1; sb = 2'b01; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin rw = 1; m2r = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin
                sa = 1;
                case (f)
                   6'b100010: alu = 3'b110;
                   6'b100100: alu = 3'b000;
                   6'b100101: alu = 3'b001;
                   6'b101010: alu = 3'b111;
                   default:   alu = 3'b010;
                endcase
             end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pcen = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin pcen = 1; ps = 2'b10; end
`ifdef MULTICYCLE_BNE_EN
         12: begin sa = 1; alu = 3'b110; ps = 2'b01; pcen = ~z; end
`endif
         default: ;
      endcase
      return {pcen, iord, mw, irw, rw, rd, m2r, sa, sb, ps, alu};
   endfunction

   // Reference: state walk of each instruction class.
   function automatic void model_seq(input logic [5:0] op, input logic [5:0] f,
                                     output int cnt, output int s[5]);
      logic [5:0] ok[5];
      logic       fok;
      ok  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      fok = 1'b0;
      foreach (ok[k]) if (ok[k] == f) fok = 1'b1;
      s   = '{0, 1, 0, 0, 0};
      cnt = 2;
      case (op)
         6'b100011: begin cnt = 5; s = '{0, 1, 2, 3, 4}; end
         6'b101011: begin cnt = 4; s = '{0, 1, 2, 5, 0}; end
         6'b000000: if (fok) begin cnt = 4; s = '{0, 1, 6, 7, 0}; end
         6'b000100: begin cnt = 3; s = '{0, 1, 8, 0, 0}; end
         6'b001000: begin cnt = 4; s = '{0, 1, 9, 10, 0}; end
         6'b000010: begin cnt = 3; s = '{0, 1, 11, 0, 0}; end
`ifdef MULTICYCLE_BNE_EN
         6'b000101: begin cnt = 3; s = '{0, 1, 12, 0, 0}; end
`endif
         default: ;
      endcase
   endfunction

   // Entered in the FETCH cycle just after the edge; leaves in the next FETCH.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode,
                            input int cnt, input int seq[5]);
      for (int i = 0; i < cnt; i++) begin
         if (i == 0) begin
            bus.OpCode = 6'($urandom);
            bus.Funct  = 6'($urandom);
         end else begin
            bus.OpCode = op;
            bus.Funct  = f;
         end
         bus.Zero = (zmode == 2) ? 1'($urandom) : zmode[0];
         #1;
         chk("state", {28'd0, bus.State}, seq[i]);
         chk("ctl", {17'd0, act_ctl()}, {17'd0, exp_ctl(seq[i], f, bus.Zero)});
         @(posedge CLK); #1;
      end
      if (cnt == 2) m_ill = 1'b1;
      else          m_count = m_count + 1;
      chk("retired", bus.Retired_Count, m_count);
      chk("retired_w4", {28'd0, bus_w.Retired_Count}, m_count & 32'hF);
      chk("illegal", {31'd0, bus.Illegal}, {31'd0, m_ill});
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;
      m_count = 0;
      m_ill   = 1'b0;
   endtask

   initial begin
      bus.OpCode = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0;
      m_count = 0; m_ill = 1'b0;

      tbl[0]  = '{6'b100011, 6'b000000, 2, 5, '{0, 1, 2, 3, 4}};
      tbl[1]  = '{6'b101011, 6'b000000, 2, 4, '{0, 1, 2, 5, 0}};
      tbl[2]  = '{6'b000000, 6'b101010, 2, 4, '{0, 1, 6, 7, 0}};
      tbl[3]  = '{6'b000000, 6'b100000, 2, 4, '{0, 1, 6, 7, 0}};
      tbl[4]  = '{6'b000000, 6'b100010, 2, 4, '{0, 1, 6, 7, 0}};
      tbl[5]  = '{6'b000000, 6'b100100, 2, 4, '{0, 1, 6, 7, 0}};
      tbl[6]  = '{6'b000000, 6'b100101, 2, 4, '{0, 1, 6, 7, 0}};
      tbl[7]  = '{6'b000100, 6'b000000, 1, 3, '{0, 1, 8, 0, 0}};
      tbl[8]  = '{6'b000100, 6'b000000, 0, 3, '{0, 1, 8, 0, 0}};
      tbl[9]  = '{6'b001000, 6'b000000, 2, 4, '{0, 1, 9, 10, 0}};
      tbl[10] = '{6'b000010, 6'b000000, 2, 3, '{0, 1, 11, 0, 0}};
      tbl[11] = '{6'b000000, 6'b000001, 2, 2, '{0, 1, 0, 0, 0}};

      // Reset state, with write enables gated while RST is high in FETCH.
      @(posedge CLK); @(posedge CLK); #1;
      chk("rst_state", {28'd0, bus.State}, 32'd0);
      chk("rst_count", bus.Retired_Count, 32'd0);
      chk("rst_illegal", {31'd0, bus.Illegal}, 32'd0);
      chk("rst_we", {28'd0, bus.PCEn, bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
      chk("rst_srcb", {30'd0, bus.ALUSrcB}, 32'd1);
      RST = 1'b0;

      foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].funct, tbl[i].zmode, tbl[i].n, tbl[i].seq);

      for (int k = 0; k < 150; k++) begin
         logic [5:0] op, f;
         case ($urandom_range(0, 7))
            0: op = 6'b100011;
            1: op = 6'b101011;
            2: op = 6'b000000;
            3: op = 6'b000100;
            4: op = 6'b001000;
            5: op = 6'b000010;
            6: op = 6'b000101;
            default: op = 6'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: f = 6'b100000;
            1: f = 6'b100010;
            2: f = 6'b100100;
            3: f = 6'b100101;
            4: f = 6'b101010;
            default: f = 6'($urandom);
         endcase
         model_seq(op, f, n, s5);
         run_instr(op, f, 2, n, s5);
      end

      // Reset mid-lw while in MEMRD.
      s5 = '{0, 1, 2, 3, 4};
      for (int i = 0; i < 3; i++) begin
         bus.OpCode = (i == 0) ? 6'b111111 : 6'b100011;
         #1;
         chk("lw_pre_state", {28'd0, bus.State}, s5[i]);
         @(posedge CLK); #1;
      end
      RST = 1'b1;
      #1;
      chk("mid_state", {28'd0, bus.State}, 32'd3);
      chk("mid_we", {28'd0, bus.PCEn, bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
      @(posedge CLK); #1;
      chk("mid_rst_state", {28'd0, bus.State}, 32'd0);
      chk("mid_rst_count", bus.Retired_Count, 32'd0);
      chk("mid_rst_illegal", {31'd0, bus.Illegal}, 32'd0);
      chk("mid_rst_we", {28'd0, bus.PCEn, bus.MemWrite, bus.IRWrite, bus.RegWrite}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      m_count = 0; m_ill = 1'b0;

      // Illegal opcode, then sticky across ten legal instructions.
      s5 = '{0, 1, 0, 0, 0};
      run_instr(6'b111111, 6'b000000, 2, 2, s5);
      for (int i = 0; i < 10; i++)
         run_instr(tbl[i].op, tbl[i].funct, tbl[i].zmode, tbl[i].n, tbl[i].seq);

      // bne with both Zero values.
      model_seq(6'b000101, 6'b000000, n, s5);
      run_instr(6'b000101, 6'b000000, 0, n, s5);
      run_instr(6'b000101, 6'b000000, 1, n, s5);

      // Counter wrap on the 4-bit instance.
      do_reset();
      s5 = '{0, 1, 9, 10, 0};
      for (int i = 0; i < 17; i++) run_instr(6'b001000, 6'b000000, 2, 4, s5);
      chk("wrap_w4", {28'd0, bus_w.Retired_Count}, 32'd1);
      chk("wrap_w32", bus.Retired_Count, 32'd17);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore FSM sequencer for the multicycle variant of the MIPS core. It replaces the single-cycle combinational control unit and drives a datapath that has a shared instruction/data memory, an instruction register, and A, B, ALUOut and Data holding registers. Each instruction is spread over 3–5 clock cycles. The unit also counts retired instructions and flags undecodable ones.

## Interface
- `Count_Width`, default 32: width of the `Retired_Count` counter.
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `OpCode`  in  6  `Instr[31:26]` from the instruction register; stable from the end of FETCH onward.
- `Funct`  in  6  `Instr[5:0]` from the instruction register.
- `Zero`  in  1  ALU zero flag.
- `PCEn`  out  1  PC load enable.
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemWrite`  out  1  memory write enable.
- `IRWrite`  out  1  instruction register load.
- `RegWrite`  out  1  register file write enable.
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd.
- `MemToReg`  out  1  write-back source: 0 = ALUOut, 1 = Data.
- `ALUSrcA`  out  1  ALU operand A: 0 = PC, 1 = A.
- `ALUSrcB`  out  2  ALU operand B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `PCSrc`  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = PCJump.
- `ALUControl`  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `State`  out  4  current state encoding, for debug.
- `Retired_Count`  out  `Count_Width`  number of completed instructions.
- `Illegal`  out  1  sticky flag: an undecodable instruction was seen.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3
  - MEMWB = 4, MEMWR = 5, RTYPEEX = 6, RTYPEWB = 7
  - BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11
  - Encodings 12–15 are unused and return to FETCH on the next edge.
- State outputs. Any signal not listed is 0, `ALUControl` defaults to 010, and all 2-bit selects default to 00.
  - FETCH: `IRWrite`=1, PCWrite=1, `ALUSrcB`=01.
  - DECODE: `ALUSrcB`=11 (branch target into ALUOut).
  - MEMADR: `ALUSrcA`=1, `ALUSrcB`=10.
  - MEMRD: `IorD`=1.
  - MEMWB: `RegWrite`=1, `MemToReg`=1.
  - MEMWR: `IorD`=1, `MemWrite`=1.
  - RTYPEEX: `ALUSrcA`=1, `ALUControl` decoded from `Funct`.
  - RTYPEWB: `RegWrite`=1, `RegDst`=1.
  - BEQEX: `ALUSrcA`=1, `ALUControl`=110, `PCSrc`=01, Branch=1.
  - ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10.
  - ADDIWB: `RegWrite`=1.
  - JEX: PCWrite=1, `PCSrc`=10.
- `PCEn` = PCWrite | (Branch & `Zero`). This is the only output that depends on a datapath input.
- Transitions from DECODE, by `OpCode`:
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 001000 (addi) → ADDIEX
  - 000010 (j) → JEX
  - anything else → FETCH, and set `Illegal`
- Transitions from MEMADR: lw → MEMRD, sw → MEMWR.
- Fixed transitions:
  - MEMRD → MEMWB
  - RTYPEEX → RTYPEWB
  - ADDIEX → ADDIWB
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX → FETCH
- Accepted R-type `Funct` codes: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt. Any other `Funct` is handled in DECODE exactly like an illegal opcode.
- `Retired_Count` increments by 1 on every edge that leaves a terminal state (MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX) for FETCH.
  - It wraps modulo 2^`Count_Width`.
  - Illegal instructions are not counted.

## Timing
- Edge with `RST`=1: State ← FETCH, `Retired_Count` ← 0, `Illegal` ← 0. Reset takes priority over any in-flight instruction; nothing is held over or completed.
- While `RST`=1, `PCEn`, `MemWrite`, `IRWrite` and `RegWrite` are forced to 0 combinationally. All other outputs show FETCH values once reset has been applied.
- Cycles per instruction, counted from FETCH to the next FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Illegal instructions take 2.
- `OpCode` and `Funct` are sampled only in DECODE and MEMADR. They must not be read in FETCH, where the instruction register is being loaded.
- Branch taken: `PCEn` is high during the BEQEX cycle only when `Zero`=1. The PC loads ALUOut on that edge.

## Configuration
- `MULTICYCLE_BNE_EN` defined:
  - Opcode 000101 (bne) in DECODE goes to BNEEX (encoding 12).
  - BNEEX outputs match BEQEX, with BranchNE=1 in place of Branch.
  - `PCEn` also includes the term BranchNE & ~`Zero`.
  - BNEEX → FETCH and counts as retired.
- `MULTICYCLE_BNE_EN` undefined: 000101 is illegal, and encoding 12 is treated as unused.

## Test plan
- Reset: hold `RST`=1 for 2 edges mid-lw (State=3) → State=0, `Retired_Count`=0, `Illegal`=0, all write enables 0 while `RST`=1.
- lw then sw: `OpCode` 100011, then 101011 → State sequences 0,1,2,3,4 and 0,1,2,5; `MemWrite`=1 only in state 5; `Retired_Count`=2.
- R-type: `Funct` 101010 → `ALUControl`=111 in RTYPEEX; `RegWrite`=1 with `RegDst`=1 in RTYPEWB; 4 cycles total.
- beq: `Zero`=1 → `PCEn`=1 in BEQEX with `PCSrc`=01. `Zero`=0 → `PCEn`=0. Both take 3 cycles and both increment the count.
- Illegal opcode: 111111 → DECODE to FETCH, `Illegal`=1 and stays 1 for the next 10 legal instructions, count unchanged. With `MULTICYCLE_BNE_EN`: 000101 with `Zero`=0 → `PCEn`=1 in state 12.
- Counter wrap: `Count_Width`=4, retire 17 addi → `Retired_Count`=1; each addi takes 4 cycles.
